// File: rtl/fifo_uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
// The frame state set always carries PARITY; the transmitter only enters it
// when built with FIFO_UART_TX_PARITY_EN defined.
package fifo_uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Even parity bit: makes the total count of ones (data + parity) even.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses bit_tick on the
// terminal count. clr restarts the count from zero.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: restart on clear or terminal count, otherwise advance.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || (cnt_q == TERM)) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bit_tick = (cnt_q == TERM);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops one byte from the FIFO read side and
// shifts it out LSB first as an 8N1 frame (8E1 when FIFO_UART_TX_PARITY_EN
// is defined). All outputs decode registered state only.
//
// Handshake with the FIFO: fifo_read_ctrl is a one-cycle pop strobe issued
// only from POP, which is reached only when the FIFO reported non-empty in
// IDLE; the popped byte is taken from fifo_read_data one cycle later in LOAD.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic              fifo_is_empty,
  input  logic [DATA_W-1:0] fifo_read_data,
  output logic              fifo_read_ctrl,
  output logic              tx,
  output logic              busy,
  output logic [CNT_W-1:0]  bytes_sent,
  output tx_state_t         state_o
);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("fifo_uart_tx: CLKS_PER_BIT must be >= 2");
  end

  localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]  sent_q, sent_d;
  logic              bit_tick;
  logic              baud_clr;
`ifdef FIFO_UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  // The bit period starts counting from the LOAD cycle so START lasts
  // exactly CLKS_PER_BIT cycles.
  assign baud_clr = (state_q == LOAD);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clr     (baud_clr),
    .bit_tick(bit_tick)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      sent_q    <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      sent_q    <= sent_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Next-state and datapath update; tx_en only gates leaving IDLE.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    sent_d    = sent_q;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: if (tx_en && !fifo_is_empty) state_d = POP;
      POP:  state_d = LOAD;
      LOAD: begin
        shift_d   = fifo_read_data;
        bit_idx_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d  = even_parity(fifo_read_data);
`endif
        state_d   = START;
      end
      START: if (bit_tick) begin
        bit_idx_d = '0;
        state_d   = DATA;
      end
      DATA: if (bit_tick) begin
        shift_d = {1'b0, shift_q[DATA_W-1:1]};
        if (bit_idx_q == LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: if (bit_tick) state_d = STOP;
`endif
      STOP: if (bit_tick) begin
        sent_d  = sent_q + CNT_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from registered state.
  always_comb begin
    tx             = 1'b1;
    fifo_read_ctrl = 1'b0;
    busy           = (state_q != IDLE);
    case (state_q)
      POP:   fifo_read_ctrl = 1'b1;
      START: tx = 1'b0;
      DATA:  tx = shift_q[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: tx = parity_q;
`endif
      default: tx = 1'b1;
    endcase
  end

  assign bytes_sent = sent_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx with CLKS_PER_BIT=4 and CNT_W=4, including a
// behavioural FIFO with registered read data. Frame length follows
// FIFO_UART_TX_PARITY_EN.
module tb_fifo_uart_tx;
  import fifo_uart_pkg::*;

  localparam int CPB   = 4;
  localparam int CNT_W = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             tx_en = 1'b0;
  logic             fifo_is_empty;
  logic [7:0]       fifo_read_data = 8'h00;
  logic             fifo_read_ctrl;
  logic             tx;
  logic             busy;
  logic [CNT_W-1:0] bytes_sent;
  tx_state_t        state_o;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .CNT_W       (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tx_en         (tx_en),
    .fifo_is_empty (fifo_is_empty),
    .fifo_read_data(fifo_read_data),
    .fifo_read_ctrl(fifo_read_ctrl),
    .tx            (tx),
    .busy          (busy),
    .bytes_sent    (bytes_sent),
    .state_o       (state_o)
  );

  // ---------------- FIFO model ----------------
  logic [7:0] mem [0:255];
  int pushes = 0;
  int pops   = 0;
  assign fifo_is_empty = (pushes == pops);

  always @(posedge clk) begin
    if (fifo_read_ctrl) begin
      fifo_read_data <= mem[pops & 255];
      pops           <= pops + 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int exp_sent = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b);
    mem[pushes & 255] = b;
    pushes++;
    exp_q.push_back(b);
  endtask

  // Step until a pop strobe is seen or the budget runs out.
  task automatic wait_pop(input int budget, output int waited, output bit found);
    waited = 0;
    found  = 1'b0;
    while (waited < budget && !found) begin
      tick();
      waited++;
      if (fifo_read_ctrl === 1'b1) found = 1'b1;
    end
  endtask

  // Called at the negedge where the pop strobe is seen (cycle 0). Checks
  // every tx cycle of the frame against a frame built from the expected
  // byte. abort_at: cycle at which to pulse rst; drop_at: cycle at which
  // to drop tx_en. Negative disables either.
  task automatic check_frame(input int abort_at, input int drop_at);
    logic [7:0]  d;
    logic [10:0] bits;
    int cyc;
    if (exp_q.size() == 0) begin
      check_eq("exp_q_empty", 32'(exp_q.size()), 32'd1);
      return;
    end
    d = exp_q.pop_front();
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
`ifdef FIFO_UART_TX_PARITY_EN
    bits[9] = d[0]^d[1]^d[2]^d[3]^d[4]^d[5]^d[6]^d[7];
`endif
    tick();
    cyc = 1;
    check_eq("pop_len", 32'(fifo_read_ctrl), 32'd0);
    check_eq("load_tx", 32'(tx), 32'd1);
    check_eq("load_busy", 32'(busy), 32'd1);
    for (int b = 0; b < NBITS; b++) begin
      for (int k = 0; k < CPB; k++) begin
        tick();
        cyc++;
        check_eq($sformatf("tx_b%0d_c%0d_d%02h", b, cyc, d), 32'(tx), 32'(bits[b]));
        if (cyc == drop_at) tx_en = 1'b0;
        if (cyc == abort_at) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          exp_sent = 0;
          check_eq("rst_tx", 32'(tx), 32'd1);
          check_eq("rst_busy", 32'(busy), 32'd0);
          check_eq("rst_sent", 32'(bytes_sent), 32'd0);
          return;
        end
      end
    end
    tick();
    exp_sent = (exp_sent + 1) % (1 << CNT_W);
    check_eq("end_idle", 32'(state_o), 32'(IDLE));
    check_eq("end_busy", 32'(busy), 32'd0);
    check_eq("end_tx", 32'(tx), 32'd1);
    check_eq("end_sent", 32'(bytes_sent), 32'(exp_sent));
  endtask

  // Expect the next pop exactly one negedge after the IDLE sample.
  task automatic next_frame(input string tag, input int abort_at, input int drop_at);
    int w;
    bit f;
    wait_pop(60, w, f);
    check_eq({tag, "_found"}, 32'(f), 32'd1);
    if (f) begin
      check_eq({tag, "_gap"}, 32'(w), 32'd1);
      check_frame(abort_at, drop_at);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int  w;
    bit  f;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_eq("rst_state", 32'(state_o), 32'(IDLE));
    check_eq("rst_tx0", 32'(tx), 32'd1);
    check_eq("rst_pop", 32'(fifo_read_ctrl), 32'd0);
    check_eq("rst_busy0", 32'(busy), 32'd0);
    check_eq("rst_cnt", 32'(bytes_sent), 32'd0);

    // Single byte frame.
    push_byte(8'hA5);
    tx_en = 1'b1;
    next_frame("t1", -1, -1);

    // Back-to-back bytes, then no further pops.
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'h3C);
    for (int i = 0; i < 3; i++) next_frame($sformatf("t2_%0d", i), -1, -1);
    check_eq("t2_count", 32'(bytes_sent), 32'd4);
    wait_pop(30, w, f);
    check_eq("t2_no_pop", 32'(f), 32'd0);

    // tx_en dropped mid-frame.
    push_byte(8'h11);
    push_byte(8'h22);
    next_frame("t3_a", -1, 10);
    wait_pop(30, w, f);
    check_eq("t3_halt", 32'(f), 32'd0);
    tx_en = 1'b1;
    next_frame("t3_b", -1, -1);

    // Reset in the middle of a frame; the popped byte is lost.
    push_byte(8'h55);
    push_byte(8'h66);
    next_frame("t4_a", 20, -1);
    next_frame("t4_b", -1, -1);

    // Counter wrap: 15 more frames take bytes_sent from 1 through 15 to 0.
    for (int i = 0; i < 15; i++) begin
      push_byte(8'($urandom_range(0, 255)));
      next_frame($sformatf("t5_%0d", i), -1, -1);
    end
    check_eq("t5_wrap", 32'(bytes_sent), 32'd0);

    // Parity-distinguishing bytes (odd and even popcount).
    push_byte(8'hA5);
    push_byte(8'h01);
    next_frame("t6_a", -1, -1);
    next_frame("t6_b", -1, -1);
    wait_pop(20, w, f);
    check_eq("final_no_pop", 32'(f), 32'd0);
    check_eq("final_exp_q", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
